// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 constants and pipeline control bundle
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Branch / cmov condition codes (ifun of jXX and cmovXX)
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Status codes
  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [2:0] CC_INIT  = 3'b100;

  // Control half of a pipeline register; data words are kept beside it
  typedef struct packed {
    logic [3:0] stat;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } pipe_ctrl_t;

endpackage

// File: rtl/y86_cond_eval.sv
// rtl/y86_cond_eval.sv - jXX/cmovXX condition evaluation from {ZF,SF,OF}
module y86_cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic zf, sf, of;
  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  // Decode the condition; unused ifun values never take the branch/move
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of);
      C_G:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_execute_stage.sv
// rtl/y86_execute_stage.sv - Y86-64 execute stage: E register, ALU, CC, M register
module y86_execute_stage
  import y86_pkg::*;
#(
  parameter int         WIDTH    = 64,
  parameter logic [3:0] RNONE    = REG_NONE,
  parameter logic [2:0] CC_RESET = CC_INIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       d_stat,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [WIDTH-1:0] d_valC,
  input  logic [WIDTH-1:0] d_valA,
  input  logic [WIDTH-1:0] d_valB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic             E_stall,
  input  logic             E_bubble,
  input  logic             M_bubble,
  input  logic             m_exc,
  input  logic             W_exc,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic [3:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic [2:0]       cc
);

  localparam pipe_ctrl_t NOP_CTRL = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0,
                                      dst_e: RNONE, dst_m: RNONE};
  localparam logic [WIDTH-1:0] POS8 = WIDTH'(8);
  localparam logic [WIDTH-1:0] NEG8 = {{(WIDTH-4){1'b1}}, 4'b1000};

  pipe_ctrl_t       e_ctrl;
  logic [WIDTH-1:0] E_valC, E_valA, E_valB;

  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [3:0]       alu_fun;
  logic             zf_new, sf_new, of_new;
  logic             set_cc, cnd;

  // E register: bubble beats stall, stall holds, otherwise capture decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ctrl <= NOP_CTRL;
      E_valC <= '0;
      E_valA <= '0;
      E_valB <= '0;
    end else if (E_bubble) begin
      e_ctrl <= NOP_CTRL;
      E_valC <= '0;
      E_valA <= '0;
      E_valB <= '0;
    end else if (!E_stall) begin
      e_ctrl <= '{stat: d_stat, icode: d_icode, ifun: d_ifun,
                  dst_e: d_dstE, dst_m: d_dstM};
      E_valC <= d_valC;
      E_valA <= d_valA;
      E_valB <= d_valB;
    end
  end

  // ALU operand and function selection from the instruction in E
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (e_ctrl.icode)
      I_RRMOVQ, I_OPQ:              alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:              alu_a = NEG8;
      I_RET, I_POPQ:                alu_a = POS8;
      default:                      alu_a = '0;
    endcase
    case (e_ctrl.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
      default:                                                 alu_b = '0;
    endcase
  end

  assign alu_fun = (e_ctrl.icode == I_OPQ) ? e_ctrl.ifun : ALU_ADD;

  // ALU result and overflow; sub is aluB - aluA
  always_comb begin
    alu_res = alu_b + alu_a;
    of_new  = 1'b0;
    case (alu_fun)
      ALU_SUB: begin
        alu_res = alu_b - alu_a;
        of_new  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != alu_b[WIDTH-1]);
      end
      ALU_AND: alu_res = alu_b & alu_a;
      ALU_XOR: alu_res = alu_b ^ alu_a;
      default: begin
        alu_res = alu_b + alu_a;
        of_new  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != alu_a[WIDTH-1]);
      end
    endcase
  end

  assign zf_new = (alu_res == '0);
  assign sf_new = alu_res[WIDTH-1];
  assign set_cc = (e_ctrl.icode == I_OPQ) && !m_exc && !W_exc;

  // Condition codes: only an OPq with no exception downstream may update them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (set_cc) begin
      cc <= {zf_new, sf_new, of_new};
    end
  end

  y86_cond_eval u_cond (
    .cc   (cc),
    .ifun (e_ctrl.ifun),
    .cnd  (cnd)
  );

  assign e_valE = alu_res;
  assign e_dstE = ((e_ctrl.icode == I_RRMOVQ) && !cnd) ? RNONE : e_ctrl.dst_e;

  // M register: bubble inserts a nop, otherwise capture execute results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || M_bubble) begin
      if (!rst_n) begin
        M_stat  <= S_AOK;
        M_icode <= I_NOP;
        M_cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= RNONE;
        M_dstM  <= RNONE;
      end else begin
        M_stat  <= S_AOK;
        M_icode <= I_NOP;
        M_cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= RNONE;
        M_dstM  <= RNONE;
      end
    end else begin
      M_stat  <= e_ctrl.stat;
      M_icode <= e_ctrl.icode;
      M_cnd   <= cnd;
      M_valE  <= alu_res;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= e_ctrl.dst_m;
    end
  end

endmodule

// File: tb/tb_y86_execute_stage.sv
// tb/tb_y86_execute_stage.sv - directed vector bench for y86_execute_stage
module tb_y86_execute_stage;

  logic        clk;
  logic        rst_n;
  logic [3:0]  d_stat, d_icode, d_ifun;
  logic [63:0] d_valC, d_valA, d_valB;
  logic [3:0]  d_dstE, d_dstM;
  logic        E_stall, E_bubble, M_bubble, m_exc, W_exc;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic [3:0]  M_stat, M_icode;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;
  logic [2:0]  cc;

  int errors = 0;
  int checks = 0;

  y86_execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM),
    .E_stall(E_stall), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .m_exc(m_exc), .W_exc(W_exc),
    .e_valE(e_valE), .e_dstE(e_dstE),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .cc(cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun;
    logic [63:0] a, b, c;
    logic [3:0]  dst_e, dst_m;
    logic        mexc;
    logic [63:0] exp_vale;
    logic [3:0]  exp_dste;
    logic        exp_cnd;
    logic [2:0]  exp_cc;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [3:0] ic, logic [3:0] fn, logic [63:0] a, logic [63:0] b,
                              logic [63:0] c, logic [3:0] de, logic [3:0] dm, logic mx,
                              logic [63:0] ev, logic [3:0] ed, logic ecnd, logic [2:0] ecc);
    vec_t v;
    v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c;
    v.dst_e = de; v.dst_m = dm; v.mexc = mx;
    v.exp_vale = ev; v.exp_dste = ed; v.exp_cnd = ecnd; v.exp_cc = ecc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] de, input logic [3:0] dm);
    d_stat = 4'h1; d_icode = ic; d_ifun = fn;
    d_valA = a; d_valB = b; d_valC = c;
    d_dstE = de; d_dstM = dm;
  endtask

  task automatic drive_nop();
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h3, 4'hF, 1'b0, 64'd12, 4'h3, 1'b1, 3'b000);
    vecs[1]  = mk(4'h6, 4'h1, 64'd1, 64'h8000000000000000, 64'd0, 4'h3, 4'hF, 1'b0,
                  64'h7FFFFFFFFFFFFFFF, 4'h3, 1'b0, 3'b001);
    vecs[2]  = mk(4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 4'h4, 4'hF, 1'b0, 64'h55, 4'h4, 1'b1, 3'b001);
    vecs[3]  = mk(4'h6, 4'h3, 64'hAA, 64'hAA, 64'd0, 4'h5, 4'hF, 1'b0, 64'h0, 4'h5, 1'b0, 3'b100);
    vecs[4]  = mk(4'h7, 4'h4, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF, 1'b0, 64'h0, 4'hF, 1'b0, 3'b100);
    vecs[5]  = mk(4'h2, 4'h4, 64'h77, 64'd0, 64'd0, 4'h5, 4'hF, 1'b0, 64'h77, 4'hF, 1'b0, 3'b100);
    vecs[6]  = mk(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'hF, 1'b0, 64'hF8, 4'h4, 1'b1, 3'b100);
    vecs[7]  = mk(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'h6, 1'b0, 64'h108, 4'h4, 1'b1, 3'b100);
    vecs[8]  = mk(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h3, 4'hF, 1'b1, 64'd3, 4'h3, 1'b1, 3'b100);
    vecs[9]  = mk(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h2, 4'hF, 1'b0, 64'h1234, 4'h2, 1'b1, 3'b100);
    vecs[10] = mk(4'h5, 4'h0, 64'd0, 64'h10, 64'd8, 4'hF, 4'h2, 1'b0, 64'h18, 4'hF, 1'b1, 3'b100);
    vecs[11] = mk(4'h6, 4'h2, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'd0, 4'h1, 4'hF, 1'b0,
                  64'h8000000000000000, 4'h1, 1'b0, 3'b010);
    vecs[12] = mk(4'h6, 4'h0, 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'd0, 4'h1, 4'hF, 1'b0,
                  64'h8000000000000000, 4'h1, 1'b1, 3'b011);
    vecs[13] = mk(4'h7, 4'h6, 64'd0, 64'd0, 64'h80, 4'hF, 4'hF, 1'b0, 64'h0, 4'hF, 1'b1, 3'b011);
    vecs[14] = mk(4'h7, 4'h7, 64'd0, 64'd0, 64'h80, 4'hF, 4'hF, 1'b0, 64'h0, 4'hF, 1'b0, 3'b011);
    vecs[15] = mk(4'h2, 4'h1, 64'd9, 64'd0, 64'd0, 4'h6, 4'hF, 1'b0, 64'd9, 4'hF, 1'b0, 3'b011);

    rst_n = 1'b0;
    E_stall = 1'b0; E_bubble = 1'b0; M_bubble = 1'b0; m_exc = 1'b0; W_exc = 1'b0;
    drive_nop();
    #12;
    chk("reset M_icode", 64'(M_icode), 64'h1);
    chk("reset M_stat", 64'(M_stat), 64'h1);
    chk("reset M_dstE", 64'(M_dstE), 64'hF);
    chk("reset M_cnd", 64'(M_cnd), 64'h0);
    chk("reset M_valE", M_valE, 64'h0);
    chk("reset cc", 64'(cc), 64'h4);
    chk("reset e_dstE", 64'(e_dstE), 64'hF);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].c,
            vecs[i].dst_e, vecs[i].dst_m);
      m_exc = vecs[i].mexc;
      tick();
      chk($sformatf("v%0d e_valE", i), e_valE, vecs[i].exp_vale);
      chk($sformatf("v%0d e_dstE", i), 64'(e_dstE), 64'(vecs[i].exp_dste));
      drive_nop();
      tick();
      m_exc = 1'b0;
      chk($sformatf("v%0d M_valE", i), M_valE, vecs[i].exp_vale);
      chk($sformatf("v%0d M_dstE", i), 64'(M_dstE), 64'(vecs[i].exp_dste));
      chk($sformatf("v%0d M_cnd", i), 64'(M_cnd), 64'(vecs[i].exp_cnd));
      chk($sformatf("v%0d M_icode", i), 64'(M_icode), 64'(vecs[i].icode));
      chk($sformatf("v%0d M_valA", i), M_valA, vecs[i].a);
      chk($sformatf("v%0d M_dstM", i), 64'(M_dstM), 64'(vecs[i].dst_m));
      chk($sformatf("v%0d cc", i), 64'(cc), 64'(vecs[i].exp_cc));
    end

    // E_stall holds the OPq in E while decode presents something else
    drive(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h3, 4'hF);
    tick();
    E_stall = 1'b1;
    drive(4'h6, 4'h3, 64'd1, 64'd1, 64'd0, 4'h6, 4'hF);
    tick();
    chk("stall e_valE", e_valE, 64'd12);
    chk("stall M_valE", M_valE, 64'd12);
    chk("stall cc", 64'(cc), 64'h0);

    // Bubble and stall together: bubble wins, and the nop leaves cc alone
    E_bubble = 1'b1;
    drive(4'h6, 4'h1, 64'd0, 64'd0, 64'd0, 4'h2, 4'hF);
    tick();
    chk("bubble e_dstE", 64'(e_dstE), 64'hF);
    chk("bubble e_valE", e_valE, 64'h0);
    E_bubble = 1'b0; E_stall = 1'b0;
    drive_nop();
    tick();
    chk("bubble M_icode", 64'(M_icode), 64'h1);
    chk("bubble M_dstE", 64'(M_dstE), 64'hF);
    chk("bubble cc", 64'(cc), 64'h0);

    // M_bubble replaces the execute result with a nop
    drive(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h3, 4'hF);
    tick();
    drive_nop();
    M_bubble = 1'b1;
    tick();
    M_bubble = 1'b0;
    chk("mbub M_icode", 64'(M_icode), 64'h1);
    chk("mbub M_dstE", 64'(M_dstE), 64'hF);
    chk("mbub M_cnd", 64'(M_cnd), 64'h0);

    // W_exc also blocks the cc update
    drive(4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 4'h3, 4'hF);
    W_exc = 1'b1;
    tick();
    drive_nop();
    tick();
    W_exc = 1'b0;
    chk("wexc cc", 64'(cc), 64'h0);

    // Asynchronous reset mid-stream, then resume
    drive(4'h6, 4'h1, 64'd1, 64'h8000000000000000, 64'd0, 4'h3, 4'hF);
    tick();
    drive_nop();
    tick();
    chk("pre-rst M_icode", 64'(M_icode), 64'h6);
    chk("pre-rst cc", 64'(cc), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst M_icode", 64'(M_icode), 64'h1);
    chk("async rst cc", 64'(cc), 64'h4);
    chk("async rst M_dstE", 64'(M_dstE), 64'hF);
    #1;
    rst_n = 1'b1;
    drive(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h3, 4'hF);
    tick();
    chk("resume e_valE", e_valE, 64'd12);
    drive_nop();
    tick();
    chk("resume M_valE", M_valE, 64'd12);
    chk("resume cc", 64'(cc), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
